// File: rtl/dqs_read_capture.sv
// DDR read capture: DQS-gated DQ sampling on both strobe edges, packed into 4-bit words
// and buffered through a small FIFO to a parallel output with a one-cycle valid strobe.
module dqs_read_capture #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned GATE_MAXSEL = 7,
    localparam int unsigned PW = $clog2(FIFO_DEPTH),
    localparam int unsigned SW = $clog2(GATE_MAXSEL + 1)
) (
    input  logic          sclk,
    input  logic          reset_n,
    input  logic          dqs,
    input  logic          dq,
    input  logic [1:0]    read,
    input  logic [SW-1:0] readclksel,
    input  logic          pause,
    output logic          dqsr90,
    output logic [3:0]    q,
    output logic          qwl,
    output logic [PW-1:0] wrpntr,
    output logic [PW-1:0] rdpntr,
    output logic          overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_OPEN
    } gate_e;

    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    gate_e         r_state;
    logic [SW-1:0] r_dly;
    logic [3:0]    r_beat;
    logic          r_dqs_d;
    logic [3:0]    r_shift;
    logic [1:0]    r_idx;
    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wrpntr;
    logic [PW-1:0] r_rdpntr;
    logic [PW:0]   r_count;
    logic [3:0]    r_q;
    logic          r_qwl;
    logic          r_overflow;

    logic          w_rise;
    logic          w_fall;
    logic          w_cap;
    logic          w_close;
    logic          w_word_done;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;
    logic [3:0]    w_word;

    // A new read request takes priority over any edge seen on the same cycle.
    always_comb begin
        w_rise      = dqs & ~r_dqs_d;
        w_fall      = ~dqs & r_dqs_d;
        w_cap       = (r_state == S_OPEN) & (w_rise | w_fall) & (read == 2'b00);
        w_close     = w_cap & w_fall & (r_beat == 4'd1);
        w_word_done = w_cap & (r_idx == 2'd3);
        w_full      = (r_count == FULL_CNT);
        w_wr        = w_word_done & ~w_full;
        w_rd        = (r_count != '0) & ~pause;
        w_word      = {dq, r_shift[2:0]};
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_dly   <= '0;
            r_beat  <= '0;
            r_dqs_d <= 1'b0;
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            r_dqs_d <= dqs;
            if (read != 2'b00) begin
                // Reload discards any partially assembled word from an earlier request.
                r_state <= S_ARMED;
                r_dly   <= readclksel;
                r_beat  <= (read == 2'b11) ? 4'd8 : 4'd4;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    S_ARMED: begin
                        if (r_dly == '0) r_state <= S_OPEN;
                        else             r_dly   <= r_dly - 1'b1;
                    end
                    S_OPEN: begin
                        if (w_cap) begin
                            r_shift[r_idx] <= dq;
                            r_idx          <= r_idx + 1'b1;
                            if (w_fall) r_beat <= r_beat - 1'b1;
                            if (w_close) begin
                                r_state <= S_IDLE;
                                r_idx   <= '0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wrpntr   <= '0;
            r_rdpntr   <= '0;
            r_count    <= '0;
            r_q        <= '0;
            r_qwl      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wrpntr] <= w_word;
                r_wrpntr        <= r_wrpntr + 1'b1;
            end
            if (w_word_done && w_full) r_overflow <= 1'b1;
            if (w_rd) begin
                r_q      <= r_mem[r_rdpntr];
                r_rdpntr <= r_rdpntr + 1'b1;
                r_qwl    <= 1'b1;
            end else begin
                r_qwl    <= 1'b0;
            end
            r_count <= r_count + {{PW{1'b0}}, w_wr} - {{PW{1'b0}}, w_rd};
        end
    end

    assign dqsr90   = r_dqs_d & (r_state == S_OPEN);
    assign q        = r_q;
    assign qwl      = r_qwl;
    assign wrpntr   = r_wrpntr;
    assign rdpntr   = r_rdpntr;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_dqs_read_capture.sv
// Scoreboarded bench for dqs_read_capture: stimulus pushes expected words, a negedge
// monitor pops and compares them whenever qwl is asserted.
module tb_dqs_read_capture;

    logic       sclk;
    logic       reset_n;
    logic       dqs;
    logic       dq;
    logic [1:0] read;
    logic [2:0] readclksel;
    logic       pause;
    logic       dqsr90;
    logic [3:0] q;
    logic       qwl;
    logic [2:0] wrpntr;
    logic [2:0] rdpntr;
    logic       overflow;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         qwl_cnt  = 0;
    int         base;
    logic [3:0] sb_q [$];

    dqs_read_capture #(.FIFO_DEPTH(8), .GATE_MAXSEL(7)) dut (
        .sclk       (sclk),
        .reset_n    (reset_n),
        .dqs        (dqs),
        .dq         (dq),
        .read       (read),
        .readclksel (readclksel),
        .pause      (pause),
        .dqsr90     (dqsr90),
        .q          (q),
        .qwl        (qwl),
        .wrpntr     (wrpntr),
        .rdpntr     (rdpntr),
        .overflow   (overflow)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge sclk) begin
        if (reset_n && qwl) begin
            qwl_cnt++;
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_qwl: got q=%0d, expected no qwl", q);
            end else begin
                check("q_word", int'(q), int'(sb_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_read(input logic [1:0] r, input logic [2:0] sel);
        read       = r;
        readclksel = sel;
        tick();
        read       = 2'b00;
    endtask

    // bits[2k] is driven on the k-th rise, bits[2k+1] on the k-th fall.
    task automatic send_periods(input logic [15:0] bits, input int n,
                                input bit push, input int exp_gate);
        logic [3:0] w;
        if (push) begin
            for (int j = 0; j < n / 2; j++) begin
                w = bits[4*j +: 4];
                sb_q.push_back(w);
            end
        end
        for (int k = 0; k < n; k++) begin
            dqs = 1'b1;
            dq  = bits[2*k];
            tick();
            check("dqsr90_rise", int'(dqsr90), exp_gate);
            dqs = 1'b0;
            dq  = bits[2*k+1];
            tick();
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        dqs        = 1'b0;
        dq         = 1'b0;
        read       = 2'b00;
        readclksel = 3'd0;
        pause      = 1'b0;

        // Reset with toggling strobe/data
        for (int i = 0; i < 5; i++) begin
            dqs = ~dqs;
            dq  = ~dq;
            tick();
        end
        check("rst_q", int'(q), 0);
        check("rst_qwl", int'(qwl), 0);
        check("rst_wrpntr", int'(wrpntr), 0);
        check("rst_rdpntr", int'(rdpntr), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_dqsr90", int'(dqsr90), 0);
        dqs     = 1'b0;
        dq      = 1'b0;
        reset_n = 1'b1;
        ticks(2);

        // Full burst, words 1010,0101,1010,0101
        base = qwl_cnt;
        send_read(2'b11, 3'd2);
        ticks(3);
        send_periods(16'b0101_1010_0101_1010, 8, 1'b1, 1);
        ticks(2);
        check("full_wrpntr", int'(wrpntr), 4);
        check("full_rdpntr", int'(rdpntr), 4);
        check("full_qwl_count", qwl_cnt - base, 4);
        // Strobe after close must be ignored
        send_periods(16'hFFFF, 2, 1'b0, 0);
        ticks(2);
        check("post_close_wrpntr", int'(wrpntr), 4);

        // Edges before the gate opens are ignored
        base = qwl_cnt;
        send_read(2'b10, 3'd3);
        send_periods(16'hFFFF, 2, 1'b0, 0);
        send_periods(16'h00C6, 4, 1'b1, 1);
        ticks(2);
        send_periods(16'hFFFF, 2, 1'b0, 0);
        ticks(2);
        check("filt_wrpntr", int'(wrpntr), 6);
        check("filt_rdpntr", int'(rdpntr), 6);
        check("filt_qwl_count", qwl_cnt - base, 2);

        // Half burst interrupted by a reload: partial beats discarded
        base = qwl_cnt;
        send_read(2'b01, 3'd1);
        ticks(2);
        send_periods(16'h0003, 1, 1'b0, 1);
        send_read(2'b01, 3'd1);
        ticks(2);
        send_periods(16'h0009, 2, 1'b1, 1);
        ticks(2);
        check("partial_wrpntr", int'(wrpntr), 7);
        check("partial_rdpntr", int'(rdpntr), 7);
        check("partial_qwl_count", qwl_cnt - base, 1);

        // Pause across 9 word writes: 8 stored, 9th dropped
        pause = 1'b1;
        tick();
        base = qwl_cnt;
        send_read(2'b11, 3'd0);
        tick();
        send_periods(16'h3C5A, 8, 1'b1, 1);
        send_read(2'b11, 3'd0);
        tick();
        send_periods(16'h9617, 8, 1'b1, 1);
        check("ovf_before_9th", int'(overflow), 0);
        send_read(2'b01, 3'd0);
        tick();
        send_periods(16'h000F, 2, 1'b0, 1);
        ticks(2);
        check("pause_qwl_count", qwl_cnt - base, 0);
        check("ovf_set", int'(overflow), 1);
        check("ovf_wrpntr", int'(wrpntr), 7);
        check("ovf_rdpntr", int'(rdpntr), 7);
        pause = 1'b0;
        tick();
        check("rd_wrap", int'(rdpntr), 0);
        ticks(7);
        check("rd_drained", int'(rdpntr), 7);
        ticks(2);
        check("drain_qwl_count", qwl_cnt - base, 8);
        check("drain_sb_empty", sb_q.size(), 0);
        check("ovf_sticky", int'(overflow), 1);

        // Asynchronous reset mid-burst
        send_read(2'b11, 3'd0);
        tick();
        send_periods(16'h0003, 1, 1'b0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_q", int'(q), 0);
        check("arst_qwl", int'(qwl), 0);
        check("arst_wrpntr", int'(wrpntr), 0);
        check("arst_rdpntr", int'(rdpntr), 0);
        check("arst_overflow", int'(overflow), 0);
        check("arst_dqsr90", int'(dqsr90), 0);
        ticks(2);
        reset_n = 1'b1;
        tick();
        base = qwl_cnt;
        send_read(2'b11, 3'd1);
        ticks(2);
        send_periods(16'hA5C3, 8, 1'b1, 1);
        ticks(3);
        check("post_rst_wrpntr", int'(wrpntr), 4);
        check("post_rst_rdpntr", int'(rdpntr), 4);
        check("post_rst_qwl_count", qwl_cnt - base, 4);
        check("final_sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
